// File: rtl/inst_trace_reorder.sv
// Commit-trace reorder buffer: accepts out-of-order completions on several
// channels, keyed by seq_num, and replays them one per cycle in seq_num order.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   in_val        per-channel completion valid (no backpressure)
//   in_seq_num    per-channel sequence number (S bits each)
//   in_pc         per-channel PC (32 bits each)
//   in_waddr      per-channel destination register (5 bits each)
//   in_wdata      per-channel writeback data (32 bits each)
//   in_wen        per-channel write enable
//   trace_*       ordered trace stream; trace_val pulses once per instruction
//   count         number of buffered entries
//   stall         producer must not complete new instructions this cycle
//   err           sticky protocol error (slot reuse or same-cycle duplicate)
module inst_trace_reorder #(
   parameter int p_num_chans    = 2,
   parameter int p_seq_num_bits = 5
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [p_num_chans-1:0]                in_val,
   input  logic [p_num_chans*p_seq_num_bits-1:0] in_seq_num,
   input  logic [p_num_chans*32-1:0]             in_pc,
   input  logic [p_num_chans*5-1:0]              in_waddr,
   input  logic [p_num_chans*32-1:0]             in_wdata,
   input  logic [p_num_chans-1:0]                in_wen,
   output logic                                  trace_val,
   output logic [31:0]                           trace_pc,
   output logic [4:0]                            trace_waddr,
   output logic [31:0]                           trace_wdata,
   output logic                                  trace_wen,
   output logic [p_seq_num_bits:0]               count,
   output logic                                  stall,
   output logic                                  err
);

   localparam int C  = p_num_chans;
   localparam int S  = p_seq_num_bits;
   localparam int D  = 1 << S;
   localparam int CW = S + 1;
   localparam int SW = CW + 1;

   // Entry storage, indexed directly by seq_num
   logic [D-1:0]  valid_q;
   logic [D-1:0]  valid_d;
   logic [31:0]   pc_q    [D];
   logic [4:0]    waddr_q [D];
   logic [31:0]   wdata_q [D];
   logic          wen_q   [D];

   logic [S-1:0]  head_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [CW-1:0] n_acc;
   logic          err_q;

   logic [S-1:0]  seq [C];
   logic [C-1:0]  acc;
   logic          bad;
   logic          drain;
   logic [SW-1:0] need;

   always_comb begin
      for (int c = 0; c < C; c++) begin
         seq[c] = in_seq_num[c*S +: S];
      end
   end

   // A write is accepted only into a free slot (pre-edge view) and only
   // by the lowest-index channel naming that slot this cycle.
   always_comb begin
      acc = '0;
      bad = 1'b0;
      for (int c = 0; c < C; c++) begin
         if (in_val[c]) begin
            acc[c] = !valid_q[seq[c]];
            for (int j = 0; j < c; j++) begin
               if (in_val[j] && (seq[j] == seq[c])) begin
                  acc[c] = 1'b0;
               end
            end
            if (!acc[c]) begin
               bad = 1'b1;
            end
         end
      end
   end

   assign drain = valid_q[head_q];

   // A write can never target the head slot while it drains: a draining
   // head is valid, so any write to it is rejected above.
   always_comb begin
      valid_d = valid_q;
      n_acc   = '0;
      if (drain) begin
         valid_d[head_q] = 1'b0;
      end
      for (int c = 0; c < C; c++) begin
         if (acc[c]) begin
            valid_d[seq[c]] = 1'b1;
            n_acc           = n_acc + CW'(1);
         end
      end
      count_d = count_q + n_acc - CW'(drain);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= '0;
         head_q      <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         trace_val   <= 1'b0;
         trace_pc    <= '0;
         trace_waddr <= '0;
         trace_wdata <= '0;
         trace_wen   <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         count_q   <= count_d;
         trace_val <= drain;
         if (bad) begin
            err_q <= 1'b1;
         end
         if (drain) begin
            trace_pc    <= pc_q[head_q];
            trace_waddr <= waddr_q[head_q];
            trace_wdata <= wdata_q[head_q];
            trace_wen   <= wen_q[head_q];
            head_q      <= head_q + S'(1);
         end
      end
   end

   // Payload needs no reset: it is only observed through a valid bit.
   always_ff @(posedge clk) begin
      for (int c = 0; c < C; c++) begin
         if (acc[c]) begin
            pc_q[seq[c]]    <= in_pc[c*32 +: 32];
            waddr_q[seq[c]] <= in_waddr[c*5 +: 5];
            wdata_q[seq[c]] <= in_wdata[c*32 +: 32];
            wen_q[seq[c]]   <= in_wen[c];
         end
      end
   end

   assign need  = {1'b0, count_q} + SW'(C);
   assign stall = need > SW'(D);
   assign count = count_q;
   assign err   = err_q;

endmodule

// File: tb/tb_inst_trace_reorder.sv
// Bench for inst_trace_reorder: directed scenarios with literal expectations
// plus randomized completions checked every cycle against a slot-map model.
module tb_inst_trace_reorder;
   localparam int C = 2;
   localparam int S = 5;
   localparam int D = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [C-1:0]  in_val;
   logic [C*S-1:0] in_seq_num;
   logic [C*32-1:0] in_pc;
   logic [C*5-1:0] in_waddr;
   logic [C*32-1:0] in_wdata;
   logic [C-1:0]  in_wen;
   logic          trace_val;
   logic [31:0]   trace_pc;
   logic [4:0]    trace_waddr;
   logic [31:0]   trace_wdata;
   logic          trace_wen;
   logic [S:0]    count;
   logic          stall;
   logic          err;

   inst_trace_reorder #(.p_num_chans(C), .p_seq_num_bits(S)) dut (
      .clk(clk), .rst(rst),
      .in_val(in_val), .in_seq_num(in_seq_num), .in_pc(in_pc),
      .in_waddr(in_waddr), .in_wdata(in_wdata), .in_wen(in_wen),
      .trace_val(trace_val), .trace_pc(trace_pc),
      .trace_waddr(trace_waddr), .trace_wdata(trace_wdata),
      .trace_wen(trace_wen), .count(count), .stall(stall), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: a map from seq_num to pending payload, plus the next seq to emit
   bit          m_valid [D];
   logic [31:0] m_pc    [D];
   logic [4:0]  m_waddr [D];
   logic [31:0] m_wdata [D];
   logic        m_wen   [D];
   int          m_head;
   bit          m_err;
   logic        e_val;
   logic [31:0] e_pc;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata;
   logic        e_wen;

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < D; i++) n += int'(m_valid[i]);
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      m_head = 0; m_err = 1'b0;
      e_val = 1'b0; e_pc = '0; e_waddr = '0; e_wdata = '0; e_wen = 1'b0;
   endtask

   task automatic model_edge();
      bit pre [D];
      int s, sj;
      bit dup;
      pre = m_valid;
      if (pre[m_head]) begin
         e_val = 1'b1;
         e_pc = m_pc[m_head]; e_waddr = m_waddr[m_head];
         e_wdata = m_wdata[m_head]; e_wen = m_wen[m_head];
         m_valid[m_head] = 1'b0;
         m_head = (m_head + 1) % D;
      end else begin
         e_val = 1'b0;
      end
      for (int c = 0; c < C; c++) begin
         if (in_val[c]) begin
            s = int'(in_seq_num[c*S +: S]);
            dup = 1'b0;
            for (int j = 0; j < c; j++) begin
               sj = int'(in_seq_num[j*S +: S]);
               if (in_val[j] && sj == s) dup = 1'b1;
            end
            if (pre[s] || dup) m_err = 1'b1;
            else begin
               m_valid[s] = 1'b1;
               m_pc[s] = in_pc[c*32 +: 32];
               m_waddr[s] = in_waddr[c*5 +: 5];
               m_wdata[s] = in_wdata[c*32 +: 32];
               m_wen[s] = in_wen[c];
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("trace_val", 64'(trace_val), 64'(e_val));
         chk("trace_pc", 64'(trace_pc), 64'(e_pc));
         chk("trace_waddr", 64'(trace_waddr), 64'(e_waddr));
         chk("trace_wdata", 64'(trace_wdata), 64'(e_wdata));
         chk("trace_wen", 64'(trace_wen), 64'(e_wen));
         chk("count", 64'(count), 64'(m_count()));
         chk("stall", 64'(stall), 64'(m_count() + C > D));
         chk("err", 64'(err), 64'(m_err));
      end
   end

   task automatic setch(int c, int s, logic [31:0] pc, logic [31:0] wd);
      logic [4:0] sb;
      sb = 5'(s % D);
      in_val[c] = 1'b1;
      in_seq_num[c*S +: S] = sb;
      in_pc[c*32 +: 32] = pc;
      in_waddr[c*5 +: 5] = pc[6:2];
      in_wdata[c*32 +: 32] = wd;
      in_wen[c] = pc[2];
   endtask

   task automatic clr();
      in_val = '0;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_edge();
      @(negedge clk);
   endtask

   int h, n;

   initial begin
      rst = 1'b0;
      in_val = '0; in_seq_num = '0; in_pc = '0;
      in_waddr = '0; in_wdata = '0; in_wen = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_tval", 64'(trace_val), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_tpc", 64'(trace_pc), 64'd0);
      chk_en = 1'b1;
      rst = 1'b1;

      // 1: two in-order completions in one cycle
      setch(0, 0, 32'h200, 32'h11);
      setch(1, 1, 32'h204, 32'h22);
      cycle(); clr();
      chk("t1_cnt2", 64'(count), 64'd2);
      chk("t1_noval", 64'(trace_val), 64'd0);
      cycle();
      chk("t1_pc0", {31'd0, trace_val, trace_pc}, {31'd0, 1'b1, 32'h200});
      chk("t1_cnt1", 64'(count), 64'd1);
      cycle();
      chk("t1_pc1", {31'd0, trace_val, trace_pc}, {31'd0, 1'b1, 32'h204});
      chk("t1_cnt0", 64'(count), 64'd0);

      // 2: reverse-order arrival
      h = m_head;
      setch(0, h + 2, 32'h308, 32'h3); cycle(); clr();
      chk("t2_blk2", 64'(trace_val), 64'd0);
      setch(0, h + 1, 32'h304, 32'h2); cycle(); clr();
      chk("t2_blk1", 64'(trace_val), 64'd0);
      setch(0, h, 32'h300, 32'h1); cycle(); clr();
      chk("t2_blk0", 64'(trace_val), 64'd0);
      chk("t2_cnt3", 64'(count), 64'd3);
      cycle();
      chk("t2_pc0", {31'd0, trace_val, trace_pc}, {31'd0, 1'b1, 32'h300});
      cycle();
      chk("t2_pc1", {31'd0, trace_val, trace_pc}, {31'd0, 1'b1, 32'h304});
      cycle();
      chk("t2_pc2", {31'd0, trace_val, trace_pc}, {31'd0, 1'b1, 32'h308});

      // 3: 40 in-order completions across the wrap
      h = m_head; n = 0;
      for (int i = 0; i < 40; i++) begin
         clr(); setch(0, h + i, 32'h1000 + 32'(4*i), 32'(i));
         cycle();
         if (trace_val) begin
            chk("t3_order", 64'(trace_pc), 64'(32'h1000 + 32'(4*n)));
            n++;
         end
      end
      clr();
      repeat (3) begin
         cycle();
         if (trace_val) begin
            chk("t3_order", 64'(trace_pc), 64'(32'h1000 + 32'(4*n)));
            n++;
         end
      end
      chk("t3_ntrace", 64'(n), 64'd40);
      chk("t3_err", 64'(err), 64'd0);

      // 5: fill with the head held back
      h = m_head;
      for (int i = 1; i <= 30; i++) begin
         clr(); setch(0, h + i, 32'h2000 + 32'(4*i), 32'(i));
         cycle();
      end
      clr();
      chk("t5_cnt30", 64'(count), 64'd30);
      chk("t5_nostall", 64'(stall), 64'd0);
      chk("t5_noval", 64'(trace_val), 64'd0);
      setch(0, h, 32'h2000, 32'h0); cycle(); clr();
      chk("t5_cnt31", 64'(count), 64'd31);
      chk("t5_stall", 64'(stall), 64'd1);
      n = 0;
      for (int i = 0; i < 34; i++) begin
         cycle();
         if (i == 0) begin
            chk("t5_cnt_dn", 64'(count), 64'd30);
            chk("t5_unstall", 64'(stall), 64'd0);
         end
         if (trace_val) begin
            chk("t5_order", 64'(trace_pc), 64'(32'h2000 + 32'(4*n)));
            n++;
         end
      end
      chk("t5_ntrace", 64'(n), 64'd31);

      // 4: slot reuse and same-cycle duplicate
      h = m_head;
      setch(0, h + 1, 32'h500, 32'hA); cycle(); clr();
      setch(0, h + 1, 32'h504, 32'hB); cycle(); clr();
      chk("t4_err", 64'(err), 64'd1);
      chk("t4_cnt1", 64'(count), 64'd1);
      setch(0, h, 32'h4FC, 32'h9); cycle(); clr();
      cycle();
      chk("t4_first", 64'(trace_wdata), 64'h9);
      cycle();
      chk("t4_keepA", {31'd0, trace_val, trace_wdata}, {31'd0, 1'b1, 32'hA});
      h = m_head;
      setch(0, h, 32'h600, 32'hC0);
      setch(1, h, 32'h604, 32'hC1);
      cycle(); clr();
      chk("t4_dupcnt", 64'(count), 64'd1);
      cycle();
      chk("t4_ch0win", {31'd0, trace_val, trace_wdata}, {31'd0, 1'b1, 32'hC0});

      // 6: asynchronous reset with entries buffered
      h = m_head;
      for (int i = 1; i <= 5; i++) begin
         clr(); setch(0, h + i, 32'h700 + 32'(4*i), 32'(i));
         cycle();
      end
      clr();
      chk("t6_cnt5", 64'(count), 64'd5);
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("t6_cnt0", 64'(count), 64'd0);
      chk("t6_tval0", 64'(trace_val), 64'd0);
      chk("t6_err0", 64'(err), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      setch(0, 0, 32'h4000, 32'h44); cycle(); clr();
      cycle();
      chk("t6_after", {31'd0, trace_val, trace_pc}, {31'd0, 1'b1, 32'h4000});
      chk("t6_cnt", 64'(count), 64'd0);

      // Random completions within a small window ahead of the head
      repeat (300) begin
         clr();
         for (int c = 0; c < C; c++) begin
            if ($urandom_range(0, 1) == 1) begin
               setch(c, m_head + int'($urandom_range(0, 7)),
                     $urandom, $urandom);
            end
         end
         cycle();
      end
      clr();
      repeat (40) cycle();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
